servo_ramp_gen: RTL and testbench

Upstream motion-profile stage for the servo PWM generator. Accepts target pulse-width commands over a valid/ready handshake. Slews the duty output `d` toward the target by a programmable step once per PWM frame. Presents `d`, `t` and `enable` to the downstream pwm_servo stage, so abrupt position commands become rate-limited servo motion. All outputs change only at frame boundaries, so the downstream counter never sees a mid-frame change to `d` or `t`.

---
 rtl/servo_pkg.sv | 23 ++
 rtl/servo_frame_timer.sv | 23 ++
 rtl/servo_ramp_gen.sv | 105 ++++++++++
 tb/tb_servo_ramp_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types, default constants and the clamp helper for the servo ramp generator.
package servo_pkg;

  typedef enum logic {
    IDLE,
    RAMP
  } ramp_state_e;

  localparam int unsigned DEFAULT_D_MIN  = 50_000;
  localparam int unsigned DEFAULT_D_MAX  = 100_000;
  localparam int unsigned DEFAULT_D_INIT = 75_000;
  localparam int unsigned DEFAULT_T_INIT = 1_000_000;

  // Widened to 64 bits so callers of any width up to 64 can share one helper.
  function automatic logic [63:0] clamp(input logic [63:0] v,
                                        input logic [63:0] lo,
                                        input logic [63:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Frame counter: runs 0..len-1 while enabled and pulses tick on the last count.
module servo_frame_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] len,
  output logic         tick
);

  logic [W-1:0] count;

  assign tick = en && (count == len - W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      count <= '0;
    else if (!en)    count <= '0;
    else if (tick)   count <= '0;
    else             count <= count + W'(1);
  end

endmodule

// File: rtl/servo_ramp_gen.sv
// Rate-limits servo duty commands: slews d toward the target by one step per PWM frame.
module servo_ramp_gen
  import servo_pkg::*;
#(
  parameter int          W      = 32,
  parameter int          SW     = 16,
  parameter int unsigned D_MIN  = DEFAULT_D_MIN,
  parameter int unsigned D_MAX  = DEFAULT_D_MAX,
  parameter int unsigned D_INIT = DEFAULT_D_INIT,
  parameter int unsigned T_INIT = DEFAULT_T_INIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [W-1:0]  cmd_target,
  input  logic [SW-1:0] cmd_step,
  input  logic [W-1:0]  period,
  input  logic          run,
  output logic [W-1:0]  d,
  output logic [W-1:0]  t,
  output logic          enable,
  output logic          busy,
  output logic          done
);

  ramp_state_e   state, state_next;
  logic [W-1:0]  tgt, tgt_in, t_new, d_ramp, d_next, t_next;
  logic [SW-1:0] step;
  logic [W:0]    mag, step_ext;
  logic          tick, xfer, up, done_next;

  servo_frame_timer #(.W(W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (enable),
    .len   (t),
    .tick  (tick)
  );

  assign xfer = cmd_valid && cmd_ready;
  assign busy = (state == RAMP);

  // Step arithmetic at W+1 bits so the distance to target never wraps.
  always_comb begin
    tgt_in   = W'(clamp(64'(cmd_target), 64'(D_MIN), 64'(D_MAX)));
    t_new    = (period < W'(2)) ? W'(2) : period;
    up       = (tgt > d);
    mag      = up ? ({1'b0, tgt} - {1'b0, d}) : ({1'b0, d} - {1'b0, tgt});
    step_ext = (W+1)'(step);
    if ((step == '0) || (step_ext >= mag)) d_ramp = tgt;
    else if (up)                            d_ramp = d + W'(step);
    else                                    d_ramp = d - W'(step);
  end

  // A tick steps toward the old target; a same-cycle transfer only affects later ticks.
  always_comb begin
    state_next = state;
    d_next     = d;
    t_next     = t;
    done_next  = 1'b0;
    if (tick) begin
      t_next = t_new;
      if (t_new < d)           d_next = t_new;
      else if (state == RAMP)  d_next = d_ramp;
      if ((state == RAMP) && (d_next == tgt)) begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
    end
    if (xfer) begin
      if (tgt_in == d_next) begin
        done_next  = 1'b1;
        state_next = IDLE;
      end else begin
        state_next = RAMP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      d         <= W'(D_INIT);
      t         <= W'(T_INIT);
      enable    <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b0;
      tgt       <= W'(D_INIT);
      step      <= '0;
    end else begin
      state     <= state_next;
      d         <= d_next;
      t         <= t_next;
      done      <= done_next;
      cmd_ready <= 1'b1;
      if (tick || !enable) enable <= run;
      if (xfer) begin
        tgt  <= tgt_in;
        step <= cmd_step;
      end
    end
  end

endmodule

// File: tb/tb_servo_ramp_gen.sv
// Directed self-checking bench for servo_ramp_gen with small clamp and period values.
module tb_servo_ramp_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_target;
  logic [15:0] cmd_step;
  logic [31:0] period;
  logic        run;
  logic [31:0] d;
  logic [31:0] t;
  logic        enable;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  servo_ramp_gen #(
    .W(32), .SW(16), .D_MIN(0), .D_MAX(100), .D_INIT(0), .T_INIT(20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .period     (period),
    .run        (run),
    .d          (d),
    .t          (t),
    .enable     (enable),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one command at a negedge; the transfer happens on the following posedge.
  task automatic applyStimulus(input logic [31:0] target, input logic [15:0] stp);
    cmd_valid  = 1'b1;
    cmd_target = target;
    cmd_step   = stp;
    @(posedge clk);
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic waitDChange(input int budget, input string tag);
    logic [31:0] prev;
    logic        changed;
    int          n;
    prev    = d;
    changed = 1'b0;
    n       = 0;
    while (!changed && n < budget) begin
      @(negedge clk);
      n++;
      if (d !== prev) changed = 1'b1;
    end
    checkOutput({tag, "_seen"}, 32'(changed), 32'd1);
  endtask

  initial begin
    int c_prev;
    int c0;
    int n;
    logic [31:0] exp_seq [4];
    exp_seq = '{32'd3, 32'd6, 32'd9, 32'd10};

    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_target = '0;
    cmd_step   = '0;
    period     = 32'd20;
    run        = 1'b1;

    // Reset state
    #12;
    checkOutput("rst_d", d, 32'd0);
    checkOutput("rst_t", t, 32'd20);
    checkOutput("rst_enable", 32'(enable), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("post_rst_enable", 32'(enable), 32'd1);

    // Ramp 0 -> 10 with step 3
    applyStimulus(32'd10, 16'd3);
    checkOutput("r1_busy", 32'(busy), 32'd1);
    c_prev = 0;
    for (int i = 0; i < 4; i++) begin
      waitDChange(40, "r1_tick");
      checkOutput("r1_d", d, exp_seq[i]);
      checkOutput("r1_done", 32'(done), (i == 3) ? 32'd1 : 32'd0);
      if (i > 0) checkOutput("r1_interval", 32'(cyc - c_prev), 32'd20);
      c_prev = cyc;
    end
    @(negedge clk);
    checkOutput("r1_done_clear", 32'(done), 32'd0);
    checkOutput("r1_busy_clear", 32'(busy), 32'd0);

    // Target 150 clamps to 100, jump with step 0, then period clamp to 20
    applyStimulus(32'd150, 16'd0);
    checkOutput("r2_busy", 32'(busy), 32'd1);
    waitDChange(40, "r2_jump");
    checkOutput("r2_d_jump", d, 32'd100);
    checkOutput("r2_done", 32'(done), 32'd1);
    waitDChange(40, "r2_clamp");
    checkOutput("r2_d_clamp", d, 32'd20);
    checkOutput("r2_t", t, 32'd20);
    checkOutput("r2_busy_idle", 32'(busy), 32'd0);

    // Period 200, ramp toward 50, retarget to 0 at d=30
    period = 32'd200;
    applyStimulus(32'd50, 16'd10);
    waitDChange(40, "r3_first");
    checkOutput("r3_d30", d, 32'd30);
    checkOutput("r3_t200", t, 32'd200);
    checkOutput("r3_no_done", 32'(done), 32'd0);
    applyStimulus(32'd0, 16'd10);
    for (int i = 0; i < 3; i++) begin
      waitDChange(250, "r3_tick");
      checkOutput("r3_d", d, 32'(20 - 10 * i));
      checkOutput("r3_done", 32'(done), (i == 2) ? 32'd1 : 32'd0);
    end

    // Target equal to current d
    @(negedge clk);
    applyStimulus(32'd0, 16'd5);
    checkOutput("eq_done", 32'(done), 32'd1);
    checkOutput("eq_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("eq_done_clear", 32'(done), 32'd0);
    checkOutput("eq_d", d, 32'd0);

    // Reset mid-ramp at d=40
    period = 32'd20;
    applyStimulus(32'd100, 16'd20);
    waitDChange(250, "r4_first");
    checkOutput("r4_d20", d, 32'd20);
    waitDChange(40, "r4_second");
    checkOutput("r4_d40", d, 32'd40);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("r4_rst_d", d, 32'd0);
    checkOutput("r4_rst_t", t, 32'd20);
    checkOutput("r4_rst_enable", 32'(enable), 32'd0);
    checkOutput("r4_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checkOutput("r4_rel_enable", 32'(enable), 32'd0);
    @(negedge clk);
    checkOutput("r4_enable_back", 32'(enable), 32'd1);
    c0 = cyc;
    applyStimulus(32'd10, 16'd10);
    checkOutput("r4_busy", 32'(busy), 32'd1);
    waitDChange(40, "r4_resume");
    checkOutput("r4_resume_d", d, 32'd10);
    checkOutput("r4_resume_interval", 32'(cyc - c0), 32'd20);
    checkOutput("r4_resume_done", 32'(done), 32'd1);

    // Drop run mid-frame
    @(negedge clk);
    applyStimulus(32'd100, 16'd10);
    waitDChange(40, "r5_first");
    checkOutput("r5_d20", d, 32'd20);
    c0 = cyc;
    repeat (5) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    checkOutput("r5_enable_hold", 32'(enable), 32'd1);
    n = 0;
    while (enable && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("r5_enable_fell", 32'(enable), 32'd0);
    checkOutput("r5_fall_interval", 32'(cyc - c0), 32'd20);
    checkOutput("r5_d_at_fall", d, 32'd30);
    repeat (60) @(negedge clk);
    checkOutput("r5_d_frozen", d, 32'd30);
    checkOutput("r5_enable_low", 32'(enable), 32'd0);
    checkOutput("r5_busy_held", 32'(busy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
